// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Load/store sequencer that sits between the pipeline MEM stage and a
// byte-addressed, big-endian data memory. It accepts one request at a time
// over a valid/ready handshake. It rejects misaligned or out-of-range requests
// without touching memory. For a clean request it holds the memory interface
// active for MEM_LAT cycles, then returns a one-cycle response. A low
// req_ready is the MEM-stage stall.
//
// Parameters
//   ADDR_W       memory byte-address width (memory spans 2**ADDR_W bytes), >= 2
//   MEM_LAT      cycles mem_enable is held per access, 1..15
//   CHECK_ALIGN  1: misaligned halfword/word faults; 0: range check only
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_write              1 = store, 0 = load
//   req_size               00 byte, 01 halfword, 10/11 word
//   req_signed             sign-extend byte/halfword loads
//   req_addr, req_wdata    byte address, right-justified store data
//   resp_valid             one-cycle completion pulse
//   resp_fault             request rejected (valid with resp_valid)
//   resp_rdata             load result, 0 for stores/faults, held until next response
//   mem_enable, mem_rw     memory Enable / ReadWrite (1 = write)
//   mem_se, mem_size       memory SE / Size
//   mem_address            memory Address
//   mem_datain             memory DataIn
//   mem_dataout            memory DataOut
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned MEM_LAT     = 1,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_fault,
    output logic [31:0]       resp_rdata,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic              mem_se,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_datain,
    input  logic [31:0]       mem_dataout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_FAULT
    } state_e;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              write_q, write_d;
    logic              se_q,    se_d;
    logic [1:0]        size_q,  size_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    // -------------------------------------------------------------------------
    // Request check, evaluated on the live request fields at the accept edge.
    // The last byte touched is computed one bit wider than the address so an
    // access running past the top of memory shows up as a carry, not a wrap.
    // -------------------------------------------------------------------------
    logic [1:0]      nbytes_m1;
    logic [ADDR_W:0] last_byte;
    logic            misaligned;
    logic            out_of_range;
    logic            req_fault;
    logic            accept;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path through the block can leave it unassigned and
        // infer a latch.
        nbytes_m1 = 2'd3;
        if (req_size == 2'b00) begin
            nbytes_m1 = 2'd0;
        end else if (req_size == 2'b01) begin
            nbytes_m1 = 2'd1;
        end

        last_byte    = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, nbytes_m1};
        out_of_range = last_byte[ADDR_W];

        misaligned = 1'b0;
        if (CHECK_ALIGN) begin
            misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00));
        end

        req_fault = misaligned || out_of_range;
        accept    = req_valid && req_ready;
    end

    // -------------------------------------------------------------------------
    // Next-state logic. The memory-side fields are loaded only for a clean
    // request, so a rejected request leaves address/data/size/se unchanged.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        se_d    = se_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_d = S_FAULT;
                        rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = LAT_INIT;
                        write_d = req_write;
                        se_d    = req_signed;
                        // Size code 11 is an alias for word on the memory side.
                        size_d  = (req_size == 2'b11) ? 2'b10 : req_size;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                    end
                end
            end

            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    // Memory already applies SE/Size, so a load takes DataOut as is.
                    rdata_d = write_q ? 32'h0 : mem_dataout;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RESP, S_FAULT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            se_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            se_q    <= se_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Enable and ReadWrite are qualified by ACCESS because the
    // memory's write path is level-sensitive. Ready is also gated by reset,
    // so no request is accepted while reset is held.
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready  = (state_q == S_IDLE) && !reset;
        resp_valid = (state_q == S_RESP) || (state_q == S_FAULT);
        resp_fault = (state_q == S_FAULT);
        mem_enable = (state_q == S_ACCESS);
        mem_rw     = (state_q == S_ACCESS) && write_q;
    end

    assign resp_rdata  = rdata_q;
    assign mem_se      = se_q;
    assign mem_size    = size_q;
    assign mem_address = addr_q;
    assign mem_datain  = wdata_q;

endmodule
